// File: rtl/cordic_pkg.sv
// Shared definitions for the stepped CORDIC rotation path.
// Holds the FSM state encoding, the default datapath widths used by the
// controller/display blocks, and the arctangent table.
// ATAN[i] = round(atan(2^-i) * 2^15 / pi), i.e. a 16-bit angle where
// +/-2^15 is +/-pi.
package cordic_pkg;

  localparam int CORDIC_W  = 16;
  localparam int CORDIC_ZW = 16;
  localparam int ATAN_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } cordic_state_t;

  localparam logic [ATAN_W-1:0] ATAN [0:15] = '{
    16'd8192, 16'd4836, 16'd2555, 16'd1297,
    16'd651,  16'd326,  16'd163,  16'd81,
    16'd41,   16'd20,   16'd10,   16'd5,
    16'd3,    16'd1,    16'd1,    16'd0
  };

  function automatic logic [ATAN_W-1:0] atan_lut(input logic [3:0] i);
    return ATAN[i];
  endfunction

endpackage

// File: rtl/cordic_microrot.sv
// Single combinational CORDIC micro-rotation in rotation mode.
// Ports:
//   x, y   in  W   current vector (signed)
//   z      in  ZW  residual angle (signed, wraps modulo 2^ZW)
//   i      in  4   iteration index (shift amount / table index)
//   x_rot, y_rot  out W   rotated vector, saturated to W bits
//   z_rot  out ZW  updated residual angle
// Direction: z >= 0 rotates counter-clockwise (subtract angle), else clockwise.
module cordic_microrot
  import cordic_pkg::*;
#(
  parameter int W  = CORDIC_W,
  parameter int ZW = CORDIC_ZW
) (
  input  logic signed [W-1:0]  x,
  input  logic signed [W-1:0]  y,
  input  logic signed [ZW-1:0] z,
  input  logic [3:0]           i,
  output logic signed [W-1:0]  x_rot,
  output logic signed [W-1:0]  y_rot,
  output logic signed [ZW-1:0] z_rot
);

  // Two guard bits: x +/- (y>>>i) can reach twice full scale.
  localparam int XW = W + 2;
  // Table is scaled for a 16-bit angle; realign it to ZW (ZW <= 32).
  localparam int ASH = 32 - ZW;

  logic signed [XW-1:0] xe, ye, xs, ys, xw, yw;
  logic signed [ZW-1:0] atan_z;

  assign xe = {{2{x[W-1]}}, x};
  assign ye = {{2{y[W-1]}}, y};
  assign xs = xe >>> i;
  assign ys = ye >>> i;

  assign atan_z = ZW'({atan_lut(i), 16'h0000} >> ASH);

  always_comb begin
    xw    = '0;
    yw    = '0;
    z_rot = z;
    if (!z[ZW-1]) begin
      xw    = xe - ys;
      yw    = ye + xs;
      z_rot = z - atan_z;
    end else begin
      xw    = xe + ys;
      yw    = ye - xs;
      z_rot = z + atan_z;
    end
  end

  // Clamp to W bits: value fits when the top three bits all agree.
  function automatic logic signed [W-1:0] sat(input logic signed [XW-1:0] v);
    if ((&v[XW-1:W-1]) || !(|v[XW-1:W-1]))
      sat = v[W-1:0];
    else if (v[XW-1])
      sat = {1'b1, {(W-1){1'b0}}};
    else
      sat = {1'b0, {(W-1){1'b1}}};
  endfunction

  assign x_rot = sat(xw);
  assign y_rot = sat(yw);

endmodule

// File: rtl/cordic_rotate_step.sv
// Iterative CORDIC rotation datapath stepped by an external button-driven
// iteration controller. One micro-rotation is applied per released step.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   load            capture x0/y0/z0, clear counters, arm (wins over a step)
//   x0, y0 (W), z0 (ZW)  initial vector / target angle
//   iter_idx (4), stop   controller index and step strobe (stop==0 => step)
//   x_out, y_out (W), z_out (ZW)  registered running vector / residual angle
//   step_cnt (4)    iterations applied since load
//   busy, done      ARMED/RUN, DONE
//   seq_err         sticky: a step arrived with an unexpected index
// The controller drives iter_idx/stop combinationally, so both are registered
// once before use; a step appears on the outputs two edges after stop falls.
module cordic_rotate_step
  import cordic_pkg::*;
#(
  parameter int W        = CORDIC_W,
  parameter int ZW       = CORDIC_ZW,
  parameter int NUM_ITER = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic signed [W-1:0]  x0,
  input  logic signed [W-1:0]  y0,
  input  logic signed [ZW-1:0] z0,
  input  logic [3:0]           iter_idx,
  input  logic                 stop,
  output logic signed [W-1:0]  x_out,
  output logic signed [W-1:0]  y_out,
  output logic signed [ZW-1:0] z_out,
  output logic [3:0]           step_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 seq_err
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ITER - 1);
  // Controller parks on index 15 with stop high when it has finished.
  localparam logic [3:0] TERM_IDX = 4'hF;

  cordic_state_t state, state_nxt;

  logic [3:0]           iter_idx_q;
  logic                 stop_q;
  logic signed [W-1:0]  x_nxt, y_nxt, x_rot, y_rot;
  logic signed [ZW-1:0] z_nxt, z_rot;
  logic [3:0]           cnt_nxt;
  logic                 err_nxt;
  logic                 apply;

  cordic_microrot #(.W(W), .ZW(ZW)) u_rot (
    .x     (x_out),
    .y     (y_out),
    .z     (z_out),
    .i     (iter_idx_q),
    .x_rot (x_rot),
    .y_rot (y_rot),
    .z_rot (z_rot)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      iter_idx_q <= '0;
      stop_q     <= 1'b1;
      x_out      <= '0;
      y_out      <= '0;
      z_out      <= '0;
      step_cnt   <= '0;
      seq_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      iter_idx_q <= iter_idx;
      stop_q     <= stop;
      x_out      <= x_nxt;
      y_out      <= y_nxt;
      z_out      <= z_nxt;
      step_cnt   <= cnt_nxt;
      seq_err    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x_out;
    y_nxt     = y_out;
    z_nxt     = z_out;
    cnt_nxt   = step_cnt;
    err_nxt   = seq_err;
    apply     = 1'b0;

    if (load) begin
      state_nxt = ARMED;
      x_nxt     = x0;
      y_nxt     = y0;
      z_nxt     = z0;
      cnt_nxt   = '0;
      err_nxt   = 1'b0;
    end else begin
      unique case (state)
        ARMED: begin
          if (!stop_q) begin
            if (iter_idx_q == 4'd0) begin
              apply     = 1'b1;
              state_nxt = (NUM_ITER == 1) ? DONE : RUN;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (!stop_q) begin
            if (iter_idx_q == step_cnt) begin
              apply = 1'b1;
              if (iter_idx_q == LAST_IDX) state_nxt = DONE;
            end else begin
              err_nxt = 1'b1;
            end
          end else if (iter_idx_q == TERM_IDX) begin
            state_nxt = DONE;
          end
        end
        default: ; // IDLE and DONE hold everything
      endcase
    end

    if (apply) begin
      x_nxt   = x_rot;
      y_nxt   = y_rot;
      z_nxt   = z_rot;
      cnt_nxt = step_cnt + 4'd1;
    end
  end

  assign busy = (state == ARMED) || (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_cordic_rotate_step.sv
// Directed bench for cordic_rotate_step. Every driven cycle advances a
// cycle-level reference model; the expected outputs for the following edge
// are queued and compared by a checker on the falling edge.
module tb_cordic_rotate_step;

  logic clk = 1'b0;
  logic reset, load, stop;
  logic signed [15:0] x0, y0, z0;
  logic [3:0] iter_idx;
  logic signed [15:0] x_out, y_out, z_out;
  logic [3:0] step_cnt;
  logic busy, done, seq_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  cordic_rotate_step dut (
    .clk(clk), .reset(reset), .load(load),
    .x0(x0), .y0(y0), .z0(z0),
    .iter_idx(iter_idx), .stop(stop),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .step_cnt(step_cnt), .busy(busy), .done(done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int x, y, z, cnt;
    bit bsy, dn, err;
  } exp_t;
  exp_t sb[$];

  int atan_t [16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81,
                      41, 20, 10, 5, 3, 1, 1, 0};

  // reference model state: mst 0=idle 1=armed 2=run 3=done
  int mx, my, mz, mcnt, mst, miq;
  bit merr, msq;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic rot(input int i);
    int xs, ys, nx, ny, nz;
    logic signed [15:0] zt;
    xs = mx >>> i;
    ys = my >>> i;
    if (mz >= 0) begin
      nx = mx - ys; ny = my + xs; nz = mz - atan_t[i];
    end else begin
      nx = mx + ys; ny = my - xs; nz = mz + atan_t[i];
    end
    mx = clamp(nx);
    my = clamp(ny);
    zt = nz[15:0];
    mz = zt;
  endtask

  // One clock cycle of stimulus plus the model's view of the next edge.
  task automatic cyc_in(input bit rs, input bit ld, input int ax, input int ay,
                        input int az, input bit st, input int idx);
    exp_t e;
    @(negedge clk);
    reset = rs; load = ld; stop = st; iter_idx = 4'(idx);
    x0 = 16'(ax); y0 = 16'(ay); z0 = 16'(az);
    if (rs) begin
      mx = 0; my = 0; mz = 0; mcnt = 0; mst = 0; merr = 0; msq = 1; miq = 0;
    end else begin
      if (ld) begin
        mx = ax; my = ay; mz = az; mcnt = 0; merr = 0; mst = 1;
      end else if (mst == 1 && !msq) begin
        if (miq == 0) begin rot(0); mcnt = 1; mst = 2; end
        else merr = 1;
      end else if (mst == 2) begin
        if (!msq) begin
          if (miq == mcnt) begin
            rot(miq); mcnt++;
            if (miq == 14) mst = 3;
          end else merr = 1;
        end else if (miq == 15) mst = 3;
      end
      msq = st; miq = idx;
    end
    e.due = cyc + 1;
    e.x = mx; e.y = my; e.z = mz; e.cnt = mcnt;
    e.bsy = (mst == 1 || mst == 2); e.dn = (mst == 3); e.err = merr;
    sb.push_back(e);
  endtask

  task automatic idle();
    cyc_in(0, 0, 0, 0, 0, 1, 0);
  endtask
  task automatic step(input int idx);
    cyc_in(0, 0, 0, 0, 0, 0, idx);
  endtask
  task automatic do_load(input int ax, input int ay, input int az);
    cyc_in(0, 1, ax, ay, az, 1, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("x_out", x_out, e.x);
      check("y_out", y_out, e.y);
      check("z_out", z_out, e.z);
      check("step_cnt", step_cnt, e.cnt);
      check("busy", busy, e.bsy);
      check("done", done, e.dn);
      check("seq_err", seq_err, e.err);
    end
  end

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  initial begin
    reset = 1; load = 0; stop = 1; iter_idx = 0; x0 = 0; y0 = 0; z0 = 0;

    // reset, then idle with a stray step that must be ignored
    cyc_in(1, 0, 0, 0, 0, 1, 0);
    cyc_in(1, 0, 0, 0, 0, 1, 0);
    idle(); step(0); idle(); idle();
    check("rst_x", x_out, 0);
    check("rst_cnt", step_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    // full rotation by +pi/4
    do_load(19898, 0, 8192);
    for (int i = 0; i < 15; i++) step(i);
    idle(); idle();
    check("rot_x_tol", iabs(x_out - 23170) <= 4, 1);
    check("rot_y_tol", iabs(y_out - 23170) <= 4, 1);
    check("rot_z_tol", iabs(z_out) <= 2, 1);
    check("rot_cnt", step_cnt, 15);
    check("rot_done", done, 1);

    // terminal marker after 8 iterations
    do_load(19898, 0, 8192);
    for (int i = 0; i < 8; i++) step(i);
    cyc_in(0, 0, 0, 0, 0, 1, 15);
    idle(); idle();
    check("term_cnt", step_cnt, 8);
    check("term_done", done, 1);

    // sequence error: 0 then 2, then 1 resumes
    do_load(19898, 0, 8192);
    step(0); idle(); step(2); idle(); idle();
    check("seq_err", seq_err, 1);
    check("seq_x", x_out, 19898);
    check("seq_y", y_out, 19898);
    check("seq_busy", busy, 1);
    step(1); idle(); idle();
    check("seq_resume_x", x_out, 9949);
    check("seq_resume_cnt", step_cnt, 2);

    // load coincident with a registered step mid-run
    do_load(19898, 0, 8192);
    for (int i = 0; i < 5; i++) step(i);
    step(5);
    do_load(1000, -2000, 3000);
    idle();
    check("ml_x", x_out, 1000);
    check("ml_y", y_out, -2000);
    check("ml_z", z_out, 3000);
    check("ml_cnt", step_cnt, 0);
    check("ml_busy", busy, 1);
    step(0); idle();

    // negative angle
    do_load(19898, 0, -8192);
    for (int i = 0; i < 15; i++) step(i);
    idle(); idle();
    check("neg_y_tol", iabs(y_out + 23170) <= 8, 1);
    check("neg_done", done, 1);

    // saturation both directions
    do_load(32767, 32767, 0);
    step(0); idle(); idle();
    check("sat_pos_y", y_out, 32767);
    check("sat_pos_x", x_out, 0);
    do_load(-32768, -32768, 0);
    step(0); idle(); idle();
    check("sat_neg_y", y_out, -32768);

    // reset mid-run discards the vector
    do_load(19898, 0, 8192);
    step(0); step(1); step(2);
    cyc_in(1, 0, 0, 0, 0, 1, 0);
    idle(); idle();
    check("rst_run_x", x_out, 0);
    check("rst_run_busy", busy, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
    check("drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_rotate_step.md
# cordic_rotate_step

Iterative CORDIC rotation datapath that consumes the iteration index and stop/step strobe produced by the button-driven iteration controller. It holds one (x, y, z) vector and performs exactly one micro-rotation each time the controller releases a step. It also checks index sequencing, flags the terminal condition, and presents the running vector for display.

## Interface
Parameters:
- W, 16: signed width of x/y datapath.
- ZW, 16: signed width of angle z; full scale ±2^(ZW-1) = ±π.
- NUM_ITER, 15: number of stepped iterations (indices 0..NUM_ITER-1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- load  in  1  capture x0/y0/z0 and arm the block.
- x0, y0  in  W  signed initial vector.
- z0  in  ZW  signed target angle.
- iter_idx  in  4  iteration index from the controller.
- stop  in  1  from the controller; 0 = perform iteration iter_idx this cycle.
- x_out, y_out  out  W  current vector, registered.
- z_out  out  ZW  residual angle, registered.
- step_cnt  out  4  iterations completed since load.
- busy  out  1  high in ARMED/RUN.
- done  out  1  high in DONE.
- seq_err  out  1  sticky; step with unexpected index was seen.

## Operation
- States: IDLE, ARMED, RUN, DONE.
- IDLE: outputs hold. load -> capture x0/y0/z0, clear step_cnt and seq_err, go to ARMED.
- ARMED: waits for the first step (stop_q==0).
  - iter_idx_q==0 -> apply iteration 0, go to RUN.
  - Any other index -> set seq_err, ignore the step, stay in ARMED.
- RUN: each cycle with stop_q==0 is one step.
  - iter_idx_q==step_cnt -> apply iteration, step_cnt+1.
  - Otherwise -> set seq_err, vector unchanged.
- Entry to DONE, from RUN only:
  - The step with index NUM_ITER-1 completes.
  - Or stop_q==1 with iter_idx_q==15 (controller terminal marker).
- DONE: holds the vector. load restarts at ARMED. reset -> IDLE.
- Iteration i:
  - d = 0 if z >= 0, else 1.
  - d=0: x' = x − (y>>>i), y' = y + (x>>>i), z' = z − ATAN[i].
  - d=1: x' = x + (y>>>i), y' = y − (x>>>i), z' = z + ATAN[i].
- Arithmetic: arithmetic shift. x/y internal width W+2, saturated to W on output. z wraps modulo 2^ZW.
- Gain K≈1.6468 is not compensated; the caller pre-scales x0.
- load in any state, including mid-RUN, aborts the current run and re-arms. load has priority over a same-cycle step.

## Timing
- iter_idx and stop are registered once (iter_idx_q, stop_q) before use, because the controller drives them combinationally.
- A step is visible on x_out/y_out/z_out two clk edges after stop goes low: input register, then update register.
- load -> busy high and outputs equal to x0/y0/z0 on the next edge.
- Back-to-back steps on consecutive cycles are legal; one iteration is applied per cycle.
- A stop==0 pulse wider than one cycle applies one step per low cycle. Index checking then flags the repeated-index steps as seq_err.
- Reset values:
  - x_out=0, y_out=0, z_out=0, step_cnt=0.
  - busy=0, done=0, seq_err=0.
  - State IDLE; iter_idx_q=0, stop_q=1.
- reset asserted mid-RUN takes effect on the next edge. The vector is lost.

## Structure
- Package cordic_pkg holds:
  - The state enum.
  - The ATAN[0:15] constant array, round(atan(2^-i)·2^15/π): 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
  - A W/ZW default localparam shared with the controller and the display blocks.
- One sub-module, cordic_microrot: combinational single iteration taking (x, y, z, i) to (x', y', z'), with the saturation logic. The top level holds the FSM, the input registers and the sequence checker.

## Test plan
- Reset then idle: reset 2 cycles -> all outputs 0, stop held 1, no state change.
- Full rotation:
  - Stimulus: load x0=19898, y0=0, z0=8192, then 15 steps with idx 0..14.
  - Required: x_out and y_out each 23170±4, |z_out|≤2, step_cnt=15, done=1.
- Terminal marker: steps idx 0..7, then stop=1 with iter_idx=15 -> DONE after 8 iterations, step_cnt=8.
- Sequence error: load, step idx 0, then step idx 2 -> seq_err=1, vector unchanged from iteration 0, still RUN. Step idx 1 then proceeds normally.
- Load mid-run: load during RUN after 5 steps, same cycle as a step -> step ignored, outputs equal the new x0/y0/z0, step_cnt=0, ARMED.
- Negative angle and saturation:
  - z0=−8192 -> y_out ends ≈ −23170.
  - x0=y0=32767, z0=0 -> x_out/y_out clamp at ±32767/−32768 with no wrap.
